pwr_vt_mode_ctrl: RTL and testbench

Controller that sequences a multi-Vt datapath between a low-leakage HVT-biased mode and a fast LVT-biased mode. It wakes the fast path on demand from the critical-path requester and returns it to low-leakage after sustained inactivity. It orders bias switching, clock enable and output isolation safely, and back-pressures the requester while the fast path is not ready. It sits beside the critical/non-critical pipelines and drives their bias select, clock enable and isolation controls.

---
 rtl/pwr_vt_mode_ctrl_if.sv | 26 ++
 rtl/pwr_vt_mode_ctrl.sv | 144 ++++++++++++++
 tb/tb_pwr_vt_mode_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pwr_vt_mode_ctrl_if.sv
// Requester/control bundle between the multi-Vt mode controller and its datapath.
// The slave side is the controller; the master side drives requests and observes controls.
interface pwr_vt_mode_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             activity_i;
  logic             force_fast_i;
  logic             force_slow_i;
  logic [1:0]       vt_mode_o;
  logic             fast_en_o;
  logic             iso_o;
  logic             stall_o;
  logic             busy_o;
  logic             mode_ack_o;
  logic [CNT_W-1:0] wake_count_o;

  modport slave (
    input  activity_i, force_fast_i, force_slow_i,
    output vt_mode_o, fast_en_o, iso_o, stall_o, busy_o, mode_ack_o, wake_count_o
  );

  modport master (
    output activity_i, force_fast_i, force_slow_i,
    input  vt_mode_o, fast_en_o, iso_o, stall_o, busy_o, mode_ack_o, wake_count_o
  );
endinterface

// File: rtl/pwr_vt_mode_ctrl.sv
// Sequences a multi-Vt datapath between low-leakage HVT bias and fast LVT bias,
// ordering bias, clock enable and isolation so the fast path is never unclamped unsettled.
module pwr_vt_mode_ctrl #(
  parameter int unsigned IDLE_THRESH   = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pwr_vt_mode_ctrl_if.slave     bus
);

  localparam int unsigned IDLE_W = $clog2(IDLE_THRESH + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] ST_SLOW       = 3'd0;
  localparam logic [2:0] ST_WAKE_BIAS  = 3'd1;
  localparam logic [2:0] ST_WAKE_ISO   = 3'd2;
  localparam logic [2:0] ST_FAST       = 3'd3;
  localparam logic [2:0] ST_SLEEP_ISO  = 3'd4;
  localparam logic [2:0] ST_SLEEP_BIAS = 3'd5;

  localparam logic [1:0] VT_HVT = 2'b00;
  localparam logic [1:0] VT_LVT = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [1:0]       vt_mode_q, vt_mode_d;
  logic             fast_en_q, fast_en_d;
  logic             iso_q, iso_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  // Next-state, counters and the registered control outputs for the next state
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idle_d     = idle_q;
    wake_cnt_d = wake_cnt_q;
    vt_mode_d  = VT_HVT;
    fast_en_d  = 1'b0;
    iso_d      = 1'b1;
    busy_d     = 1'b0;
    ack_d      = 1'b0;

    unique case (state_q)
      ST_SLOW: begin
        idle_d = '0;
        if (!bus.force_slow_i && (bus.activity_i || bus.force_fast_i)) begin
          state_d  = ST_WAKE_BIAS;
          settle_d = '0;
          if (wake_cnt_q != '1) wake_cnt_d = wake_cnt_q + CNT_W'(1);
        end
      end
      ST_WAKE_BIAS: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_WAKE_ISO;
        else settle_d = settle_q + SET_W'(1);
      end
      ST_WAKE_ISO: begin
        state_d = ST_FAST;
        idle_d  = '0;
      end
      ST_FAST: begin
        if (bus.force_slow_i) begin
          state_d = ST_SLEEP_ISO;
        end else if (bus.activity_i || bus.force_fast_i) begin
          idle_d = '0;
        end else if (idle_q == IDLE_W'(IDLE_THRESH - 1)) begin
          state_d = ST_SLEEP_ISO;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_SLEEP_ISO: begin
        state_d  = ST_SLEEP_BIAS;
        settle_d = '0;
        idle_d   = '0;
      end
      ST_SLEEP_BIAS: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_SLOW;
        else settle_d = settle_q + SET_W'(1);
      end
      default: state_d = ST_SLOW;
    endcase

    unique case (state_d)
      ST_WAKE_BIAS: begin
        vt_mode_d = VT_LVT;
        busy_d    = 1'b1;
      end
      ST_WAKE_ISO, ST_SLEEP_ISO: begin
        vt_mode_d = VT_LVT;
        fast_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_FAST: begin
        vt_mode_d = VT_LVT;
        fast_en_d = 1'b1;
        iso_d     = 1'b0;
      end
      ST_SLEEP_BIAS: busy_d = 1'b1;
      default: ;
    endcase

    ack_d = ((state_d == ST_FAST) && (state_q == ST_WAKE_ISO)) ||
            ((state_d == ST_SLOW) && (state_q == ST_SLEEP_BIAS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SLOW;
      settle_q   <= '0;
      idle_q     <= '0;
      wake_cnt_q <= '0;
      vt_mode_q  <= VT_HVT;
      fast_en_q  <= 1'b0;
      iso_q      <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      idle_q     <= idle_d;
      wake_cnt_q <= wake_cnt_d;
      vt_mode_q  <= vt_mode_d;
      fast_en_q  <= fast_en_d;
      iso_q      <= iso_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  // Requester is held off whenever the fast path is not fully up
  assign bus.stall_o      = bus.activity_i & (state_q != ST_FAST);
  assign bus.vt_mode_o    = vt_mode_q;
  assign bus.fast_en_o    = fast_en_q;
  assign bus.iso_o        = iso_q;
  assign bus.busy_o       = busy_q;
  assign bus.mode_ack_o   = ack_q;
  assign bus.wake_count_o = wake_cnt_q;

endmodule

// File: tb/tb_pwr_vt_mode_ctrl.sv
// Directed scoreboard bench for pwr_vt_mode_ctrl: default-parameter instance for sequencing,
// a CNT_W=2 instance for counter saturation and mid-sequence reset.
module tb_pwr_vt_mode_ctrl;

  localparam int M_SLOW = 0;
  localparam int M_WB   = 1;
  localparam int M_WI   = 2;
  localparam int M_FAST = 3;
  localparam int M_SI   = 4;
  localparam int M_SB   = 5;

  typedef struct packed {
    logic [1:0] vt;
    logic       fen;
    logic       iso;
    logic       stall;
    logic       busy;
    logic       ack;
    logic [7:0] wc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  pwr_vt_mode_ctrl_if #(.CNT_W(8)) bus0 ();
  pwr_vt_mode_ctrl_if #(.CNT_W(2)) bus1 ();

  pwr_vt_mode_ctrl #(.IDLE_THRESH(16), .SETTLE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pwr_vt_mode_ctrl #(.IDLE_THRESH(2), .SETTLE_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // {vt, fen, iso, busy} expected in each sequencing state
  function automatic logic [4:0] dec(input int m);
    case (m)
      M_WB:    return 5'b10_0_1_1;
      M_WI:    return 5'b10_1_1_1;
      M_FAST:  return 5'b10_1_0_0;
      M_SI:    return 5'b10_1_1_1;
      M_SB:    return 5'b00_0_1_1;
      default: return 5'b00_0_1_0;
    endcase
  endfunction

  task automatic step(input int sel, input string tag, input logic act, input logic ff,
                      input logic fs, input int m, input logic ack, input int wc);
    obs_t e, o;
    logic [4:0] d;
    string t;
    if (sel == 0) begin
      bus0.activity_i = act; bus0.force_fast_i = ff; bus0.force_slow_i = fs;
      bus1.activity_i = 1'b0; bus1.force_fast_i = 1'b0; bus1.force_slow_i = 1'b0;
    end else begin
      bus1.activity_i = act; bus1.force_fast_i = ff; bus1.force_slow_i = fs;
      bus0.activity_i = 1'b0; bus0.force_fast_i = 1'b0; bus0.force_slow_i = 1'b0;
    end
    d = dec(m);
    e.vt    = d[4:3];
    e.fen   = d[2];
    e.iso   = d[1];
    e.busy  = d[0];
    e.stall = act & (m != M_FAST);
    e.ack   = ack;
    e.wc    = 8'(wc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    if (sel == 0)
      o = '{bus0.vt_mode_o, bus0.fast_en_o, bus0.iso_o, bus0.stall_o, bus0.busy_o,
            bus0.mode_ack_o, bus0.wake_count_o};
    else
      o = '{bus1.vt_mode_o, bus1.fast_en_o, bus1.iso_o, bus1.stall_o, bus1.busy_o,
            bus1.mode_ack_o, 8'(bus1.wake_count_o)};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: got vt=%b fen=%b iso=%b stall=%b busy=%b ack=%b wc=%0d, exp vt=%b fen=%b iso=%b stall=%b busy=%b ack=%b wc=%0d",
             t, o.vt, o.fen, o.iso, o.stall, o.busy, o.ack, o.wc,
             e.vt, e.fen, e.iso, e.stall, e.busy, e.ack, e.wc);
    end
    n_vec++;
    assert ((o.iso | ((o.vt == 2'b10) & o.fen)) === 1'b1) else begin
      n_err++;
      $error("FAIL %s_iso_inv: got iso=%b vt=%b fen=%b, exp iso=1 unless vt=10 and fen=1",
             t, o.iso, o.vt, o.fen);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.activity_i = 1'b0; bus0.force_fast_i = 1'b0; bus0.force_slow_i = 1'b0;
    bus1.activity_i = 1'b0; bus1.force_fast_i = 1'b0; bus1.force_slow_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(0, "reset", 0, 0, 0, M_SLOW, 0, 0);
    rst = 1'b0;
    step(0, "slow_idle", 0, 0, 0, M_SLOW, 0, 0);

    // Single activity pulse: wake, then idle back to sleep
    step(0, "pulse", 1, 0, 0, M_SLOW, 0, 0);
    for (int i = 0; i < 4; i++) step(0, "wake_bias", 0, 0, 0, M_WB, 0, 1);
    step(0, "wake_iso", 0, 0, 0, M_WI, 0, 1);
    step(0, "fast_ack", 0, 0, 0, M_FAST, 1, 1);
    for (int i = 0; i < 15; i++) step(0, "fast_idle", 0, 0, 0, M_FAST, 0, 1);
    step(0, "sleep_iso", 0, 0, 0, M_SI, 0, 1);
    for (int i = 0; i < 4; i++) step(0, "sleep_bias", 0, 0, 0, M_SB, 0, 1);
    step(0, "slow_ack", 0, 0, 0, M_SLOW, 1, 1);
    step(0, "slow_hold", 0, 0, 0, M_SLOW, 0, 1);

    // Held activity: six stalled cycles, then idle restart at the last idle cycle
    step(0, "act_slow", 1, 0, 0, M_SLOW, 0, 1);
    for (int i = 0; i < 4; i++) step(0, "act_wb", 1, 0, 0, M_WB, 0, 2);
    step(0, "act_wi", 1, 0, 0, M_WI, 0, 2);
    step(0, "act_fast", 1, 0, 0, M_FAST, 1, 2);
    for (int i = 0; i < 15; i++) step(0, "idle_a", 0, 0, 0, M_FAST, 0, 2);
    step(0, "idle_rescue", 1, 0, 0, M_FAST, 0, 2);
    for (int i = 0; i < 16; i++) step(0, "idle_b", 0, 0, 0, M_FAST, 0, 2);
    step(0, "sleep_iso2", 0, 0, 0, M_SI, 0, 2);
    for (int i = 0; i < 4; i++) step(0, "sb_act", 1, 0, 0, M_SB, 0, 2);
    step(0, "slow_one", 1, 0, 0, M_SLOW, 1, 2);
    for (int i = 0; i < 4; i++) step(0, "rewake_wb", 1, 0, 0, M_WB, 0, 3);
    step(0, "rewake_wi", 1, 0, 0, M_WI, 0, 3);
    step(0, "rewake_fast", 0, 0, 0, M_FAST, 1, 3);

    // force_fast suppresses idle sleep; both forces act as force_slow
    for (int i = 0; i < 20; i++) step(0, "ff_hold", 0, 1, 0, M_FAST, 0, 3);
    step(0, "both_fast", 0, 1, 1, M_FAST, 0, 3);
    step(0, "both_si", 0, 1, 1, M_SI, 0, 3);
    for (int i = 0; i < 4; i++) step(0, "both_sb", 0, 1, 1, M_SB, 0, 3);
    step(0, "fs_slow_ack", 1, 1, 1, M_SLOW, 1, 3);
    for (int i = 0; i < 3; i++) step(0, "fs_slow_hold", 1, 0, 1, M_SLOW, 0, 3);
    step(0, "fs_released", 0, 0, 0, M_SLOW, 0, 3);

    // Small instance: saturation after five wakes, then reset inside WAKE_BIAS
    for (int i = 0; i < 5; i++) begin
      step(1, "sat_slow", 0, 1, 0, M_SLOW, (i > 0), (i > 3) ? 3 : i);
      step(1, "sat_wb", 0, 0, 0, M_WB, 0, (i + 1 > 3) ? 3 : i + 1);
      step(1, "sat_wi", 0, 0, 0, M_WI, 0, (i + 1 > 3) ? 3 : i + 1);
      step(1, "sat_fast", 0, 0, 1, M_FAST, 1, (i + 1 > 3) ? 3 : i + 1);
      step(1, "sat_si", 0, 0, 0, M_SI, 0, (i + 1 > 3) ? 3 : i + 1);
      step(1, "sat_sb", 0, 0, 0, M_SB, 0, (i + 1 > 3) ? 3 : i + 1);
    end
    step(1, "sat_done", 0, 0, 0, M_SLOW, 1, 3);
    step(1, "rst_wake", 0, 1, 0, M_SLOW, 0, 3);
    rst = 1'b1;
    step(1, "rst_in_wb", 0, 1, 0, M_WB, 0, 3);
    rst = 1'b0;
    step(1, "rst_slow", 0, 0, 0, M_SLOW, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
